spi_master_ctrl: RTL and testbench

Parametrised SPI master that replaces the single-mode driver. It generates SCLK internally from the system clock and supports all four CPOL/CPHA modes, MSB- or LSB-first ordering and multiple slave selects. It performs full-duplex transfers of 1..SPI_MAXLEN bits per command. It sits between the register/command layer and the SPI pins, and reports received data with a one-cycle valid pulse.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_clk_gen.sv | 41 ++++
 rtl/spi_master_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master controller.
package spi_pkg;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } spi_state_t;

    // Per-transfer mode, latched at the accept edge.
    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    // Width of the half-period counter; never narrower than one bit.
    function automatic int half_cnt_width(input int clk_divide);
        return (clk_divide / 2 > 1) ? $clog2(clk_divide / 2) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: one-cycle tick every CLK_DIVIDE/2 cycles while enabled,
// tagged as a leading or trailing SCLK edge.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIVIDE = 100
) (
    input  logic clk,
    input  logic sreset,
    input  logic en,
    output logic tick,
    output logic leading,
    output logic trailing
);

    localparam int H  = CLK_DIVIDE / 2;
    localparam int CW = half_cnt_width(CLK_DIVIDE);
    localparam logic [CW-1:0] LAST = CW'(H - 1);

    logic [CW-1:0] cnt;
    logic          phase;

    assign tick     = en && (cnt == LAST);
    assign leading  = tick && !phase;
    assign trailing = tick && phase;

    // Count half-periods while active; held at zero when idle so the first tick lands H cycles after accept.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (sreset || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: FSM, bit counter, TX/RX shift registers and slave-select decode.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIVIDE = 100,
    parameter int SPI_MAXLEN = 16,
    parameter int NUM_SS     = 4
) (
    input  logic                          clk,
    input  logic                          sreset,
    input  logic                          start_cmd,
    output logic                          spi_drv_rdy,
    input  logic [$clog2(SPI_MAXLEN):0]   n_clks,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic [$clog2(NUM_SS)-1:0]     ss_sel,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          lsb_first,
    output logic [SPI_MAXLEN-1:0]         rx_miso,
    output logic                          rx_valid,
    output logic                          SCLK,
    output logic                          MOSI,
    input  logic                          MISO,
    output logic [NUM_SS-1:0]             SS_N
);

    localparam int LEN_W = $clog2(SPI_MAXLEN) + 1;
    localparam int SS_W  = $clog2(NUM_SS);
    localparam logic [LEN_W-1:0] MAXLEN = LEN_W'(SPI_MAXLEN);

    spi_state_t              state, state_next;
    spi_mode_t               mode;
    logic [LEN_W-1:0]        n_len, bit_cnt, n_req;
    logic [SPI_MAXLEN-1:0]   tx_sr, rx_sr, tx_aligned, rx_aligned;
    logic [NUM_SS-1:0]       ss_dec;
    logic                    tick, leading, trailing;
    logic                    accept, sclk_edge, done, sample_ev, advance_ev;

    // Next bit to drive from a shift register for the given order.
    function automatic logic first_bit(input logic [SPI_MAXLEN-1:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[SPI_MAXLEN-1];
    endfunction

    // Shift register after consuming one bit.
    function automatic logic [SPI_MAXLEN-1:0] shift_out(input logic [SPI_MAXLEN-1:0] sr, input logic lsb);
        return lsb ? (sr >> 1) : (sr << 1);
    endfunction

    spi_clk_gen #(.CLK_DIVIDE(CLK_DIVIDE)) u_clk_gen (
        .clk      (clk),
        .sreset   (sreset),
        .en       (state != IDLE),
        .tick     (tick),
        .leading  (leading),
        .trailing (trailing)
    );

    assign spi_drv_rdy = (state == IDLE);
    assign n_req       = (n_clks > MAXLEN) ? MAXLEN : n_clks;
    // MSB-first data is left-aligned so the first bit always sits at the top.
    assign tx_aligned  = lsb_first ? tx_data : (tx_data << (MAXLEN - n_req));
    // LSB-first bits enter from the top and are right-aligned at completion.
    assign rx_aligned  = mode.lsb_first ? (rx_sr >> (MAXLEN - n_len)) : rx_sr;

    // Active-low one-hot select; out-of-range indices leave every line high.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            ss_dec[i] = (ss_sel != SS_W'(i));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (sreset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and per-cycle strobes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        accept     = 1'b0;
        sclk_edge  = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_cmd && (n_clks != '0)) begin
                    accept     = 1'b1;
                    state_next = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    sclk_edge  = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    if (bit_cnt == n_len) state_next = TRAIL;
                    else                  sclk_edge  = 1'b1;
                end
            end
            TRAIL: begin
                if (tick) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Map the SCLK edge onto sample/advance actions for the latched phase.
    always_comb begin
        sample_ev  = 1'b0;
        advance_ev = 1'b0;
        if (sclk_edge) begin
            if (mode.cpha) begin
                sample_ev  = trailing;
                advance_ev = leading;
            end else begin
                sample_ev  = leading;
                advance_ev = trailing && (bit_cnt != n_len - LEN_W'(1));
            end
        end
    end

    // Datapath: latch command, toggle SCLK, shift TX/RX, drive selects and results.
    always_ff @(posedge clk) begin
        if (sreset) begin
            // NOTE: shift registers and the result register are ordinary flops, so reset clears them all.
            SS_N     <= '1;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            rx_valid <= 1'b0;
            rx_miso  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            n_len    <= '0;
            mode     <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE) SCLK <= cpol;
            if (accept) begin
                n_len   <= n_req;
                mode    <= {cpol, cpha, lsb_first};
                bit_cnt <= '0;
                rx_sr   <= '0;
                SS_N    <= ss_dec;
                if (cpha) begin
                    MOSI  <= 1'b0;
                    tx_sr <= tx_aligned;
                end else begin
                    MOSI  <= first_bit(tx_aligned, lsb_first);
                    tx_sr <= shift_out(tx_aligned, lsb_first);
                end
            end
            if (sclk_edge) SCLK <= ~SCLK;
            if (sclk_edge && trailing) bit_cnt <= bit_cnt + LEN_W'(1);
            if (sample_ev) begin
                rx_sr <= mode.lsb_first ? {MISO, rx_sr[SPI_MAXLEN-1:1]}
                                        : {rx_sr[SPI_MAXLEN-2:0], MISO};
            end
            if (advance_ev) begin
                MOSI  <= first_bit(tx_sr, mode.lsb_first);
                tx_sr <= shift_out(tx_sr, mode.lsb_first);
            end
            if (done) begin
                SS_N     <= '1;
                SCLK     <= mode.cpol;
                MOSI     <= 1'b0;
                rx_miso  <= rx_aligned;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl with a behavioural SPI slave and scoreboard.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    localparam int H = 2;

    logic        clk = 1'b0;
    logic        sreset, start_cmd, spi_drv_rdy;
    logic [4:0]  n_clks;
    logic [15:0] tx_data, rx_miso;
    logic [1:0]  ss_sel;
    logic        cpol, cpha, lsb_first, rx_valid, SCLK, MOSI, miso;
    logic [3:0]  SS_N;
    logic        loopback = 1'b0;
    logic        slv_miso = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_accept = 0;

    typedef struct {
        int          n;
        logic [15:0] exp_rx;
        logic [15:0] exp_tx;
        logic [3:0]  exp_ss;
        logic        cpol;
        int          accept_cyc;
    } sb_t;

    typedef struct {
        int          n;
        logic [15:0] word;
        bit          cpha;
        bit          lsb;
    } slv_cfg_t;

    typedef struct {
        logic [15:0] mosi_word;
        int          edges;
        logic [3:0]  ss;
    } slv_res_t;

    sb_t      sb_q[$];
    slv_cfg_t slv_cfg_q[$];
    slv_res_t slv_res_q[$];

    assign miso = loopback ? MOSI : slv_miso;

    spi_master_ctrl #(.CLK_DIVIDE(4), .SPI_MAXLEN(16), .NUM_SS(4)) dut (
        .clk         (clk),
        .sreset      (sreset),
        .start_cmd   (start_cmd),
        .spi_drv_rdy (spi_drv_rdy),
        .n_clks      (n_clks),
        .tx_data     (tx_data),
        .ss_sel      (ss_sel),
        .cpol        (cpol),
        .cpha        (cpha),
        .lsb_first   (lsb_first),
        .rx_miso     (rx_miso),
        .rx_valid    (rx_valid),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .MISO        (miso),
        .SS_N        (SS_N)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mask(input int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return m[15:0];
    endfunction

    function automatic logic [3:0] ss_exp(input logic [1:0] s);
        logic [3:0] v;
        v    = 4'hF;
        v[s] = 1'b0;
        return v;
    endfunction

    function automatic logic slave_bit(input slv_cfg_t c, input int i);
        if (i >= c.n) return 1'b0;
        return c.word[c.lsb ? i : c.n - 1 - i];
    endfunction

    // Behavioural SPI slave: shifts out its word and records MOSI in the frame's bit order.
    initial begin : slave_model
        slv_cfg_t c;
        slv_res_t r;
        logic     prev_sclk = 1'b0;
        bit       prev_active = 1'b0;
        bit       active;
        int       e = 0;
        int       bi;
        c = '{0, 16'h0, 1'b0, 1'b0};
        r = '{16'h0, 0, 4'hF};
        forever begin
            @(posedge clk);
            #1;
            active = (SS_N != 4'hF);
            if (active && !prev_active) begin
                if (slv_cfg_q.size() > 0) c = slv_cfg_q.pop_front();
                e = 0;
                r = '{16'h0, 0, SS_N};
                slv_miso = c.cpha ? 1'b0 : slave_bit(c, 0);
            end else if (active && (SCLK !== prev_sclk)) begin
                bi = e / 2;
                if (e % 2 == 0) begin
                    if (c.cpha) slv_miso = slave_bit(c, bi);
                    else if (bi < c.n) r.mosi_word[c.lsb ? bi : c.n - 1 - bi] = MOSI;
                end else begin
                    if (c.cpha) begin
                        if (bi < c.n) r.mosi_word[c.lsb ? bi : c.n - 1 - bi] = MOSI;
                    end else begin
                        slv_miso = slave_bit(c, bi + 1);
                    end
                end
                e++;
            end else if (!active && prev_active) begin
                r.edges = e;
                slv_res_q.push_back(r);
            end
            prev_active = active;
            prev_sclk   = SCLK;
        end
    end

    // Monitor: every rx_valid pops one expected transfer and one slave frame.
    initial begin : monitor
        sb_t      x;
        slv_res_t r;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                check("rx_valid_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    x = sb_q.pop_front();
                    check("rx_miso", rx_miso, x.exp_rx);
                    check("done_latency", cyc - x.accept_cyc, (2 * x.n + 2) * H);
                    check("rdy_at_done", spi_drv_rdy, 1);
                    check("sclk_idle_after", SCLK, x.cpol);
                    check("slave_frame_seen", slv_res_q.size() != 0, 1);
                    if (slv_res_q.size() != 0) begin
                        r = slv_res_q.pop_front();
                        check("mosi_word", r.mosi_word, x.exp_tx);
                        check("sclk_edges", r.edges, 2 * x.n);
                        check("ss_n_active", r.ss, x.exp_ss);
                    end
                end
                @(negedge clk);
                check("rx_valid_pulse", rx_valid, 0);
            end
        end
    end

    // Issue one command at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int nclk, input logic [15:0] tx, input logic [1:0] ss,
                        input bit p, input bit ph, input bit lsb,
                        input logic [15:0] sword, input bit completes);
        int n;
        int w = 0;
        while (!spi_drv_rdy && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("rdy_before_cmd", spi_drv_rdy, 1);
        n         = (nclk > 16) ? 16 : nclk;
        n_clks    = 5'(nclk);
        tx_data   = tx;
        ss_sel    = ss;
        cpol      = p;
        cpha      = ph;
        lsb_first = lsb;
        start_cmd = 1'b1;
        if (n != 0) begin
            slv_cfg_q.push_back('{n, sword, ph, lsb});
            if (completes) sb_q.push_back('{n, sword & mask(n), tx & mask(n), ss_exp(ss), p, cyc + 1});
            last_accept = cyc + 1;
        end
        @(negedge clk);
        start_cmd = 1'b0;
        n_clks    = 5'($urandom);
        tx_data   = 16'($urandom);
        ss_sel    = 2'($urandom);
        cpol      = 1'($urandom);
        cpha      = 1'($urandom);
        lsb_first = 1'($urandom);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (!spi_drv_rdy && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("transfer_completes", spi_drv_rdy, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        int busy, ss_act, tog, vcnt, acc, gap, guard;
        bit seen;
        logic prev;
        logic [15:0] w;

        sreset = 1'b1; start_cmd = 1'b0; n_clks = '0; tx_data = '0;
        ss_sel = '0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_ss_n", SS_N, 4'hF);
        check("reset_sclk", SCLK, 0);
        check("reset_mosi", MOSI, 0);
        check("reset_rdy", spi_drv_rdy, 1);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_miso", rx_miso, 0);
        sreset = 1'b0;
        cpol   = 1'b0;
        @(negedge clk);

        // Mode 0 MSB-first loopback.
        loopback = 1'b1;
        send(8, 16'h00A5, 2'd0, 0, 0, 0, 16'h00A5, 1);
        wait_idle();
        loopback = 1'b0;

        // Mode 3 LSB-first against the slave model.
        cpol = 1'b1; cpha = 1'b1;
        repeat (2) @(negedge clk);
        check("mode3_sclk_idle_high", SCLK, 1);
        send(12, 16'h0ABC, 2'd2, 1, 1, 1, 16'h0123, 1);
        wait_idle();

        // Zero-length command is a no-op.
        cpol = 1'b0;
        @(negedge clk);
        n_clks = '0; tx_data = 16'hFFFF; ss_sel = 2'd1; start_cmd = 1'b1;
        busy = 0; ss_act = 0; tog = 0; vcnt = 0; prev = SCLK;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start_cmd = 1'b0;
            if (!spi_drv_rdy) busy++;
            if (SS_N != 4'hF) ss_act++;
            if (SCLK !== prev) tog++;
            if (rx_valid) vcnt++;
            prev = SCLK;
        end
        check("noop_rdy_low_cycles", busy, 0);
        check("noop_ss_active_cycles", ss_act, 0);
        check("noop_sclk_toggles", tog, 0);
        check("noop_rx_valid_cycles", vcnt, 0);

        // Length clamped to SPI_MAXLEN.
        send(20, 16'($urandom), 2'd3, 0, 1, 0, 16'($urandom), 1);
        wait_idle();

        // Reset in the middle of an 8-bit transfer.
        send(8, 16'hFFFF, 2'd0, 0, 0, 0, 16'($urandom), 0);
        while (cyc < last_accept + 9) @(negedge clk);
        sreset = 1'b1;
        @(negedge clk);
        check("midreset_ss_n", SS_N, 4'hF);
        check("midreset_sclk", SCLK, 0);
        check("midreset_mosi", MOSI, 0);
        check("midreset_rdy", spi_drv_rdy, 1);
        check("midreset_rx_miso", rx_miso, 0);
        sreset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rx_valid) vcnt++;
        end
        check("midreset_no_rx_valid", vcnt, 0);
        slv_res_q.delete();

        // start_cmd held high with tx changing every cycle: back-to-back transfers.
        cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0; ss_sel = 2'd1; n_clks = 5'd6;
        start_cmd = 1'b1;
        acc = 0; gap = 0; seen = 1'b0; guard = 0;
        while (acc < 4 && guard < 2000) begin
            tx_data = 16'($urandom);
            if (spi_drv_rdy) begin
                w = 16'($urandom);
                slv_cfg_q.push_back('{6, w, 1'b1, 1'b0});
                sb_q.push_back('{6, w & mask(6), tx_data & mask(6), ss_exp(2'd1), 1'b0, cyc + 1});
                acc++;
            end
            if (SS_N == 4'hF) gap++;
            else begin
                if (seen && gap != 0) check("b2b_ss_high_cycles", gap, 1);
                seen = 1'b1;
                gap  = 0;
            end
            @(negedge clk);
            guard++;
        end
        start_cmd = 1'b0;
        check("b2b_accepted", acc, 4);
        check("b2b_ss_high_cycles", gap, 1);
        check("b2b_last_ss_active", SS_N, ss_exp(2'd1));
        wait_idle();

        // Randomised transfers across modes, lengths and selects.
        for (int t = 0; t < 20; t++) begin
            send($urandom_range(1, 20), 16'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 16'($urandom), 1);
            wait_idle();
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
